// File: rtl/fp_add_seq_if.sv
// -----------------------------------------------------------------------------
// fp_add_seq_if
// Handshake bundle for the fp_add_seq floating-point add/subtract sequencer.
//
// Signals:
//   in_valid  : requester has operands on a/b/sub
//   in_ready  : sequencer idle and able to accept
//   a, b      : IEEE-754 operands
//   sub       : 1 = a-b, 0 = a+b
//   out_valid : result available
//   out_ready : consumer accepts result
//   result    : IEEE-754 result
//   overflow  : result saturated to infinity
//   zero      : result is +/-0
//
// Modports:
//   master : requester/consumer side (drives operands, accepts results)
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface fp_add_seq_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              overflow;
  logic              zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, overflow, zero
  );
endinterface

// File: rtl/fp_add_seq.sv
// -----------------------------------------------------------------------------
// fp_add_seq
// Multi-cycle IEEE-754 single-precision add/subtract sequencer. One operation
// in flight; states IDLE -> ALIGN -> ADD -> NORM -> DONE. The accept edge
// moves IDLE to ALIGN and counts as the first of four edges; out_valid rises
// on the edge that enters DONE. A single 24-bit barrel shifter is shared:
// right shift for exponent alignment in ALIGN, left shift for normalisation
// in NORM. Rounding is truncation; denormal inputs are flushed to zero.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fp_add_seq_if.slave (operand / result valid-ready handshakes)
//
// Optional feature macro: FPADD_SPECIAL_EN
//   defined   : Inf/NaN operands detected at accept and resolved to the IEEE
//               special result (canonical NaN 7FC00000), same latency
//   undefined : exponent 255 inputs are treated as ordinary normals
// -----------------------------------------------------------------------------
module fp_add_seq #(
  parameter int EXP_W       = 8,
  parameter int MAN_W       = 23,
  parameter int ALIGN_CLAMP = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  fp_add_seq_if.slave bus
);

  localparam int MANT_W  = MAN_W + 1;
  localparam int SUM_W   = MANT_W + 1;
  localparam int WORD_W  = 1 + EXP_W + MAN_W;
  localparam int SHAMT_W = $clog2(MANT_W + 1);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W:0]   CLAMP   = ALIGN_CLAMP[EXP_W:0];

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t state;

  logic              sx, sy;
  logic [EXP_W-1:0]  ex, ey;
  logic [MANT_W-1:0] mx, my;
  logic [SUM_W-1:0]  sum;
  logic              special_q;
  logic [WORD_W-1:0] special_word_q;

  logic              out_valid_q;
  logic [WORD_W-1:0] result_q;
  logic              overflow_q;
  logic              zero_q;

  // ---------------------------------------------------------------------------
  // Unpack at accept: flush denormals, apply subtract to B's sign, and order
  // the operands so X carries the larger magnitude.
  // ---------------------------------------------------------------------------
  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MANT_W-1:0] a_mant, b_mant;
  logic              swap;

  assign a_sign = bus.a[WORD_W-1];
  assign b_sign = bus.b[WORD_W-1] ^ bus.sub;
  assign a_exp  = bus.a[WORD_W-2:MAN_W];
  assign b_exp  = bus.b[WORD_W-2:MAN_W];
  assign a_mant = (a_exp != '0) ? {1'b1, bus.a[MAN_W-1:0]} : '0;
  assign b_mant = (b_exp != '0) ? {1'b1, bus.b[MAN_W-1:0]} : '0;
  assign swap   = {b_exp, b_mant} > {a_exp, a_mant};

  logic              special_hit;
  logic [WORD_W-1:0] special_word;

`ifdef FPADD_SPECIAL_EN
  logic a_nan, b_nan, a_inf, b_inf;

  assign a_nan = (a_exp == EXP_MAX) && (bus.a[MAN_W-1:0] != '0);
  assign b_nan = (b_exp == EXP_MAX) && (bus.b[MAN_W-1:0] != '0);
  assign a_inf = (a_exp == EXP_MAX) && (bus.a[MAN_W-1:0] == '0);
  assign b_inf = (b_exp == EXP_MAX) && (bus.b[MAN_W-1:0] == '0);

  assign special_hit = a_nan | b_nan | a_inf | b_inf;

  // b_sign already includes the subtract, so Inf - Inf of equal stored
  // signs shows up here as opposite-sign infinities.
  always_comb begin
    special_word = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
      special_word = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
    else if (a_inf)
      special_word = {a_sign, EXP_MAX, {MAN_W{1'b0}}};
    else if (b_inf)
      special_word = {b_sign, EXP_MAX, {MAN_W{1'b0}}};
  end
`else
  assign special_hit  = 1'b0;
  assign special_word = '0;
`endif

  // ---------------------------------------------------------------------------
  // Exponent difference and leading-zero count feeding the shared shifter.
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0]   exp_diff;
  logic               align_clamp;
  logic [SHAMT_W-1:0] lz;
  logic [EXP_W-1:0]   lz_ext;
  logic               lz_found;

  assign exp_diff    = ex - ey;
  assign align_clamp = {1'b0, exp_diff} >= CLAMP;
  assign lz_ext      = {{(EXP_W-SHAMT_W){1'b0}}, lz};

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (sum[i])
          lz_found = 1'b1;
        else
          lz = lz + SHAMT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared barrel shifter. A left shift is done by bit-reversing around the
  // right-shift stages, so only one set of shift stages exists. Inputs are
  // held at zero outside ALIGN and NORM.
  // ---------------------------------------------------------------------------
  logic [MANT_W-1:0]  shift_in, shift_out, shift_stage;
  logic [SHAMT_W-1:0] shift_amt;
  logic               shift_left;

  function automatic logic [MANT_W-1:0] bit_reverse(input logic [MANT_W-1:0] v);
    for (int i = 0; i < MANT_W; i++)
      bit_reverse[i] = v[MANT_W-1-i];
  endfunction

  always_comb begin
    shift_in   = '0;
    shift_amt  = '0;
    shift_left = 1'b0;
    case (state)
      ALIGN: begin
        shift_in  = my;
        shift_amt = exp_diff[SHAMT_W-1:0];
      end
      NORM: begin
        shift_in   = sum[MANT_W-1:0];
        shift_amt  = lz;
        shift_left = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    shift_stage = shift_left ? bit_reverse(shift_in) : shift_in;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (shift_amt[i])
        shift_stage = shift_stage >> (1 << i);
    end
    shift_out = shift_left ? bit_reverse(shift_stage) : shift_stage;
  end

  // ---------------------------------------------------------------------------
  // Normalisation result, registered on the NORM -> DONE edge.
  // ---------------------------------------------------------------------------
  logic [EXP_W:0]    exp_inc;
  logic [WORD_W-1:0] norm_word;
  logic              norm_ovf;
  logic              norm_zero;

  assign exp_inc = {1'b0, ex} + {{EXP_W{1'b0}}, 1'b1};

  always_comb begin
    norm_word = '0;
    norm_ovf  = 1'b0;
    norm_zero = 1'b0;
    if (special_q) begin
      norm_word = special_word_q;
    end else if (sum == '0) begin
      // Exact cancellation is always +0.
      norm_zero = 1'b1;
    end else if (sum[SUM_W-1]) begin
      if (exp_inc >= {1'b0, EXP_MAX}) begin
        norm_word = {sx, EXP_MAX, {MAN_W{1'b0}}};
        norm_ovf  = 1'b1;
      end else begin
        norm_word = {sx, exp_inc[EXP_W-1:0], sum[MANT_W-1:1]};
      end
    end else if (ex <= lz_ext) begin
      norm_word = {sx, {(WORD_W-1){1'b0}}};
      norm_zero = 1'b1;
    end else begin
      norm_word = {sx, ex - lz_ext, shift_out[MAN_W-1:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered result outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sx             <= 1'b0;
      sy             <= 1'b0;
      ex             <= '0;
      ey             <= '0;
      mx             <= '0;
      my             <= '0;
      sum            <= '0;
      special_q      <= 1'b0;
      special_word_q <= '0;
      out_valid_q    <= 1'b0;
      result_q       <= '0;
      overflow_q     <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (swap) begin
              sx <= b_sign;
              ex <= b_exp;
              mx <= b_mant;
              sy <= a_sign;
              ey <= a_exp;
              my <= a_mant;
            end else begin
              sx <= a_sign;
              ex <= a_exp;
              mx <= a_mant;
              sy <= b_sign;
              ey <= b_exp;
              my <= b_mant;
            end
            special_q      <= special_hit;
            special_word_q <= special_word;
            state          <= ALIGN;
          end
        end
        ALIGN: begin
          my    <= align_clamp ? '0 : shift_out;
          state <= ADD;
        end
        ADD: begin
          // X holds the larger magnitude, so the difference never goes negative.
          if (sx ^ sy)
            sum <= {1'b0, mx} - {1'b0, my};
          else
            sum <= {1'b0, mx} + {1'b0, my};
          state <= NORM;
        end
        NORM: begin
          result_q    <= norm_word;
          overflow_q  <= norm_ovf;
          zero_q      <= norm_zero;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule
